// File: rtl/mj32_pkg.sv
// Shared core constants: store opcodes (also used by store decode) and the
// store-buffer drain state encoding.
package mj32_pkg;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_SB   = 3'b001;
  localparam logic [2:0] OP_SH   = 3'b010;
  localparam logic [2:0] OP_SW   = 3'b011;

  typedef enum logic {
    DRN_IDLE = 1'b0,
    DRN_REQ  = 1'b1
  } drain_state_t;

endpackage

// File: rtl/store_fifo.sv
// DEPTH-entry synchronous FIFO of {word address, byte enables, write data}
// with a registered occupancy count and per-entry word-address hit outputs.
module store_fifo
  import mj32_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [AW-3:0]          push_waddr,
  input  logic [3:0]             push_be,
  input  logic [31:0]            push_wdata,
  input  logic                   pop,
  output logic [AW-3:0]          head_waddr,
  output logic [3:0]             head_be,
  output logic [31:0]            head_wdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  input  logic [AW-3:0]          cmp_waddr,
  output logic [DEPTH-1:0]       cmp_hit
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-3:0] waddr_q [DEPTH];
  logic [3:0]    be_q    [DEPTH];
  logic [31:0]   wdata_q [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Entry payload carries no reset: validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      waddr_q[wr_ptr] <= push_waddr;
      be_q[wr_ptr]    <= push_be;
      wdata_q[wr_ptr] <= push_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_waddr = waddr_q[rd_ptr];
  assign head_be    = be_q[rd_ptr];
  assign head_wdata = wdata_q[rd_ptr];

  // Slot i is live when its distance from the head is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    logic [PW-1:0] off;
    assign off        = PW'(i) - rd_ptr;
    assign cmp_hit[i] = ({1'b0, off} < count) && (waddr_q[i] == cmp_waddr);
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: alignment check, lane/byte-enable build,
// queueing, and a req/ack drain to data memory with load-hazard detection.
module store_buffer
  import mj32_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [2:0]    operation,
  input  logic [AW-1:0] address,
  input  logic [31:0]   data_in,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic          mem_ack,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_hazard,
  output logic          misalign,
  output logic [AW-1:0] misalign_addr,
  output logic          empty
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]    ofs;
  logic          is_store, aligned, take, push, bad;
  logic [3:0]    new_be;
  logic [31:0]   new_wdata;
  logic          pop, full;
  logic [CW-1:0] count;
  logic [AW-3:0] head_waddr;
  logic [3:0]    head_be;
  logic [31:0]   head_wdata;
  logic [DEPTH-1:0] hit;
  logic [AW-1:0] hold_addr;
  logic [3:0]    hold_be;
  logic [31:0]   hold_wdata;
  logic          unused_ld_lo;
  drain_state_t  state_q, state_d;

  assign ofs = address[1:0];

  always_comb begin
    is_store  = 1'b0;
    aligned   = 1'b1;
    new_be    = 4'b0000;
    new_wdata = data_in;
    case (operation)
      OP_SB: begin
        is_store  = 1'b1;
        new_be    = 4'b0001 << ofs;
        new_wdata = {4{data_in[7:0]}};
      end
      OP_SH: begin
        is_store  = 1'b1;
        aligned   = ~address[0];
        new_be    = 4'b0011 << ofs;
        new_wdata = {2{data_in[15:0]}};
      end
      OP_SW: begin
        is_store  = 1'b1;
        aligned   = (ofs == 2'b00);
        new_be    = 4'b1111;
      end
      default: ;
    endcase
  end

  assign st_ready = ~full;
  assign take     = st_valid & st_ready & is_store;
  assign push     = take & aligned;
  assign bad      = take & ~aligned;

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign <= bad;
      if (bad) misalign_addr <= address;
    end
  end

  store_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_waddr (address[AW-1:2]),
    .push_be    (new_be),
    .push_wdata (new_wdata),
    .pop        (pop),
    .head_waddr (head_waddr),
    .head_be    (head_be),
    .head_wdata (head_wdata),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .cmp_waddr  (ld_addr[AW-1:2]),
    .cmp_hit    (hit)
  );

  assign ld_hazard    = |hit;
  assign unused_ld_lo = ^ld_addr[1:0];

  always_ff @(posedge clk) begin
    if (rst) state_q <= DRN_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      DRN_IDLE: if (count != '0) state_d = DRN_REQ;
      DRN_REQ: begin
        if (mem_ack) begin
          pop = 1'b1;
          if (count <= CW'(1)) state_d = DRN_IDLE;
        end
      end
      default: state_d = DRN_IDLE;
    endcase
  end

  // Head is stable in REQ (pop only on ack); the hold copy keeps the bus
  // quiet at the last written value once the drain goes idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_addr  <= '0;
      hold_be    <= '0;
      hold_wdata <= '0;
    end else if (state_q == DRN_REQ) begin
      hold_addr  <= {head_waddr, 2'b00};
      hold_be    <= head_be;
      hold_wdata <= head_wdata;
    end
  end

  assign mem_req   = (state_q == DRN_REQ);
  assign mem_addr  = mem_req ? {head_waddr, 2'b00} : hold_addr;
  assign mem_be    = mem_req ? head_be : hold_be;
  assign mem_wdata = mem_req ? head_wdata : hold_wdata;

endmodule
